// File: rtl/color_threshold_ctrl_pkg.sv
// Shared types and constants for the colour-threshold controller.
package color_ctrl_pkg;

  localparam int unsigned CFG_AW      = 2;
  localparam int unsigned CFG_DW      = 8;
  localparam int unsigned THR_W       = 8;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam int unsigned S_THR_DEFAULT = 80;
  localparam int unsigned V_THR_DEFAULT = 180;

  localparam logic [CFG_AW-1:0] ADDR_S    = 2'd0;
  localparam logic [CFG_AW-1:0] ADDR_V    = 2'd1;
  localparam logic [CFG_AW-1:0] ADDR_CTRL = 2'd2;
  localparam logic [CFG_AW-1:0] ADDR_RSVD = 2'd3;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    RUN       = 2'd1,
    COMMIT    = 2'd2
  } state_e;

endpackage

// File: rtl/color_threshold_ctrl_if.sv
// Host-side configuration write port (valid/ready).
interface color_threshold_ctrl_if;

  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [color_ctrl_pkg::CFG_AW-1:0]    cfg_addr;
  logic [color_ctrl_pkg::CFG_DW-1:0]    cfg_data;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);

endinterface

// File: rtl/vs_edge_detect.sv
// Registers VS once and flags the first cycle it shows its active level.
module vs_edge_detect #(
  parameter int unsigned VS_POL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic vs_edge_c
);

  logic vs_act_c;
  logic vs_act_q;

  assign vs_act_c = (VS_POL != 0) ? vs : ~vs;

  // Reset to active so a frame already in sync at reset release raises no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_act_q <= 1'b1;
    else     vs_act_q <= vs_act_c;
  end

  assign vs_edge_c = vs_act_c && !vs_act_q;

endmodule

// File: rtl/color_threshold_ctrl.sv
// Shadowed S/V threshold config committed at frame boundaries, plus per-frame hit count.
// Optional forced commit on stalled video: define COLOR_CTRL_TIMEOUT_EN.
module color_threshold_ctrl
  import color_ctrl_pkg::*;
#(
  parameter int unsigned S_DEFAULT      = S_THR_DEFAULT,
  parameter int unsigned V_DEFAULT      = V_THR_DEFAULT,
  parameter int unsigned CNT_W          = 22,
  parameter int unsigned VS_POL         = 1
`ifdef COLOR_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  color_threshold_ctrl_if.slave  cfg,
  input  logic                   hsv_vs,
  input  logic                   hsv_de,
  input  logic                   color,
  output logic [THR_W-1:0]       s_threshold,
  output logic [THR_W-1:0]       v_threshold,
  output logic                   detect_en,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       hit_count,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
`ifdef COLOR_CTRL_TIMEOUT_EN
  output logic                   timeout_flag,
`endif
  output logic                   cfg_pending
);

  state_e             state_q, state_d;
  logic               vs_edge_c;
  logic               wr_c, wr_shadow_c, to_hit_c;
  logic               commit_c, latch_c, clr_acc_c;
  logic               cfg_ready_q;
  logic [THR_W-1:0]   s_shadow_q, v_shadow_q;
  logic               en_shadow_q;
  logic [CNT_W-1:0]   acc_q;

  vs_edge_detect #(.VS_POL(VS_POL)) u_vs_edge (
    .clk       (clk),
    .rst       (rst),
    .vs        (hsv_vs),
    .vs_edge_c (vs_edge_c)
  );

  assign wr_c          = cfg.cfg_valid && cfg_ready_q;
  assign wr_shadow_c   = wr_c && (cfg.cfg_addr != ADDR_RSVD);
  assign cfg.cfg_ready = cfg_ready_q;

`ifdef COLOR_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_set_c;

  assign to_hit_c = cfg_pending && (state_q != COMMIT) &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign to_set_c = to_hit_c && !vs_edge_c;

  // Counts stalled cycles with a pending config; any edge or commit restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (vs_edge_c || commit_c)                   to_cnt_q <= '0;
      else if (cfg_pending && (state_q != COMMIT)) to_cnt_q <= to_cnt_q + TO_W'(1);

      if (to_set_c)
        timeout_flag <= 1'b1;
      else if (wr_c && (cfg.cfg_addr == ADDR_CTRL) && cfg.cfg_data[7])
        timeout_flag <= 1'b0;
    end
  end
`else
  assign to_hit_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_SYNC;
    else     state_q <= state_d;
  end

  // Next state; a write landing in the edge cycle joins that commit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_SYNC, RUN: begin
        if (vs_edge_c)     state_d = (cfg_pending || wr_shadow_c) ? COMMIT : RUN;
        else if (to_hit_c) state_d = COMMIT;
      end
      COMMIT:  state_d = wr_shadow_c ? COMMIT : RUN;
      default: state_d = WAIT_SYNC;
    endcase
  end

  // Per-state controls; no count is published until one full frame has been seen.
  always_comb begin
    commit_c  = 1'b0;
    latch_c   = 1'b0;
    clr_acc_c = 1'b0;
    unique case (state_q)
      WAIT_SYNC: clr_acc_c = vs_edge_c;
      RUN: begin
        latch_c   = vs_edge_c;
        clr_acc_c = vs_edge_c;
      end
      COMMIT: begin
        commit_c  = 1'b1;
        latch_c   = vs_edge_c;
        clr_acc_c = vs_edge_c;
      end
      default: ;
    endcase
  end

  // Config shadows, live copies and the host-facing ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_shadow_q  <= THR_W'(S_DEFAULT);
      v_shadow_q  <= THR_W'(V_DEFAULT);
      en_shadow_q <= 1'b1;
      s_threshold <= THR_W'(S_DEFAULT);
      v_threshold <= THR_W'(V_DEFAULT);
      detect_en   <= 1'b1;
      cfg_pending <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      cfg_ready_q <= (state_d != COMMIT);
      if (wr_c) begin
        unique case (cfg.cfg_addr)
          ADDR_S:    s_shadow_q  <= cfg.cfg_data;
          ADDR_V:    v_shadow_q  <= cfg.cfg_data;
          ADDR_CTRL: en_shadow_q <= cfg.cfg_data[0];
          default:   ;
        endcase
      end
      if (commit_c) begin
        s_threshold <= s_shadow_q;
        v_threshold <= v_shadow_q;
        detect_en   <= en_shadow_q;
        cfg_pending <= 1'b0;
      end else if (wr_shadow_c) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  // Saturating hit accumulator and per-frame publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      hit_count  <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= latch_c;
      if (latch_c) begin
        hit_count <= acc_q;
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
      if (clr_acc_c || vs_edge_c)
        acc_q <= '0;
      else if (hsv_de && !color && detect_en && (acc_q != {CNT_W{1'b1}}))
        acc_q <= acc_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_color_threshold_ctrl.sv
// Directed bench for color_threshold_ctrl; covers the timeout path when COLOR_CTRL_TIMEOUT_EN is defined.
module tb_color_threshold_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsv_vs, hsv_de, color;
  logic [7:0]  s_threshold, v_threshold;
  logic        detect_en, frame_done, cfg_pending;
  logic [21:0] hit_count;
  logic [15:0] frame_cnt;
`ifdef COLOR_CTRL_TIMEOUT_EN
  logic        timeout_flag;
`endif

  int errors = 0;
  int checks = 0;

  color_threshold_ctrl_if cfg_bus ();

  color_threshold_ctrl #(
    .S_DEFAULT (80),
    .V_DEFAULT (180),
    .CNT_W     (22),
    .VS_POL    (1)
`ifdef COLOR_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg          (cfg_bus.slave),
    .hsv_vs       (hsv_vs),
    .hsv_de       (hsv_de),
    .color        (color),
    .s_threshold  (s_threshold),
    .v_threshold  (v_threshold),
    .detect_en    (detect_en),
    .frame_done   (frame_done),
    .hit_count    (hit_count),
    .frame_cnt    (frame_cnt),
`ifdef COLOR_CTRL_TIMEOUT_EN
    .timeout_flag (timeout_flag),
`endif
    .cfg_pending  (cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = a;
    cfg_bus.cfg_data  = d;
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic pix(input int n, input int m);
    for (int i = 0; i < n; i++) begin
      hsv_de = 1'b1;
      color  = (i < m) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    hsv_de = 1'b0;
    color  = 1'b1;
  endtask

  // One-cycle VS pulse; returns at the negedge after the edge has been processed.
  task automatic vs_pulse();
    hsv_vs = 1'b1;
    @(negedge clk);
    hsv_vs = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hsv_vs = 1'b0; hsv_de = 1'b0; color = 1'b1;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_data = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_s", 32'(s_threshold), 32'd80);
    chk("rst_v", 32'(v_threshold), 32'd180);
    chk("rst_en", 32'(detect_en), 32'd1);
    chk("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    chk("rst_hit", 32'(hit_count), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_pend", 32'(cfg_pending), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);

    // Matches before the first edge never reach hit_count.
    pix(8, 5);
    vs_pulse();
    chk("e1_fd", 32'(frame_done), 32'd0);
    chk("e1_hit", 32'(hit_count), 32'd0);
    chk("e1_fcnt", 32'(frame_cnt), 32'd0);
    chk("e1_ready", 32'(cfg_bus.cfg_ready), 32'd1);

    // Frame of 100 DE cycles, 37 matches, plus a mid-frame S write.
    pix(100, 37);
    wr(2'd0, 8'h40);
    chk("ws_pend", 32'(cfg_pending), 32'd1);
    repeat (3) @(negedge clk);
    chk("ws_hold", 32'(s_threshold), 32'd80);
    chk("f1_fd_pre", 32'(frame_done), 32'd0);
    vs_pulse();
    chk("f1_fd", 32'(frame_done), 32'd1);
    chk("f1_hit", 32'(hit_count), 32'd37);
    chk("f1_fcnt", 32'(frame_cnt), 32'd1);
    chk("f1_ready_commit", 32'(cfg_bus.cfg_ready), 32'd0);
    chk("f1_s_commit", 32'(s_threshold), 32'd80);
    @(negedge clk);
    chk("f1_s_live", 32'(s_threshold), 32'h40);
    chk("f1_ready_after", 32'(cfg_bus.cfg_ready), 32'd1);
    chk("f1_pend_after", 32'(cfg_pending), 32'd0);
    chk("f1_fd_off", 32'(frame_done), 32'd0);

    // Disable detection; this frame still counts with the old enable.
    wr(2'd2, 8'h00);
    pix(10, 10);
    vs_pulse();
    chk("f2_hit", 32'(hit_count), 32'd10);
    chk("f2_fcnt", 32'(frame_cnt), 32'd2);
    @(negedge clk);
    chk("f2_en_live", 32'(detect_en), 32'd0);
    pix(50, 50);
    vs_pulse();
    chk("f3_hit", 32'(hit_count), 32'd0);
    chk("f3_fd", 32'(frame_done), 32'd1);
    chk("f3_fcnt", 32'(frame_cnt), 32'd3);
    chk("f3_ready", 32'(cfg_bus.cfg_ready), 32'd1);

    // V write in the very edge cycle joins that commit.
    repeat (2) @(negedge clk);
    hsv_vs = 1'b1;
    wr(2'd1, 8'h90);
    hsv_vs = 1'b0;
    chk("ev_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    chk("ev_v_commit", 32'(v_threshold), 32'd180);
    chk("ev_fcnt", 32'(frame_cnt), 32'd4);
    @(negedge clk);
    chk("ev_v_live", 32'(v_threshold), 32'h90);
    chk("ev_pend", 32'(cfg_pending), 32'd0);

    // Reserved address is accepted and discarded.
    wr(2'd3, 8'hFF);
    chk("rsvd_pend", 32'(cfg_pending), 32'd0);
    wr(2'd2, 8'h01);
    pix(20, 20);
    vs_pulse();
    chk("f5_hit", 32'(hit_count), 32'd0);
    @(negedge clk);
    chk("f5_en", 32'(detect_en), 32'd1);
    chk("f5_s", 32'(s_threshold), 32'h40);
    chk("f5_v", 32'(v_threshold), 32'h90);

    // Reset mid-frame: the next edge is treated as the first.
    pix(7, 7);
    rst = 1'b1;
    #1;
    chk("mrst_s", 32'(s_threshold), 32'd80);
    chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_v", 32'(v_threshold), 32'd180);
    chk("mrst_hit", 32'(hit_count), 32'd0);
    pix(5, 5);
    vs_pulse();
    chk("mrst_e1_fd", 32'(frame_done), 32'd0);
    chk("mrst_e1_hit", 32'(hit_count), 32'd0);
    pix(6, 3);
    vs_pulse();
    chk("mrst_e2_hit", 32'(hit_count), 32'd3);
    chk("mrst_e2_fcnt", 32'(frame_cnt), 32'd1);
    chk("mrst_e2_fd", 32'(frame_done), 32'd1);

`ifdef COLOR_CTRL_TIMEOUT_EN
    // Stalled VS: pending write forced in after 16 pending cycles.
    repeat (2) @(negedge clk);
    wr(2'd0, 8'h10);
    repeat (16) @(negedge clk);
    chk("to_flag", 32'(timeout_flag), 32'd1);
    chk("to_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    chk("to_s_commit", 32'(s_threshold), 32'd80);
    @(negedge clk);
    chk("to_s_live", 32'(s_threshold), 32'h10);
    chk("to_pend", 32'(cfg_pending), 32'd0);
    wr(2'd2, 8'h81);
    chk("to_flag_clr", 32'(timeout_flag), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
